// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters, flush and stats
module branch_target_predictor #(
  parameter int ADDR_W   = 32,
  parameter int IDX_BITS = 4,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc4,
  output logic              hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_dest,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc4,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_dest,
  input  logic              upd_mispred,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int ENTRIES = 2**IDX_BITS;
  localparam int TAG_W = ADDR_W - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_WN = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT = CTR_BITS'(1 << (CTR_BITS-1));
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q  [ENTRIES];
  logic [ADDR_W-1:0]   dest_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q  [ENTRIES];

  logic [IDX_BITS-1:0] idx, uidx;
  logic [TAG_W-1:0]    ptag, utag, e_tag;
  logic                uhit, wr, fwd, e_valid;
  logic [CTR_BITS-1:0] u_ctr, new_ctr, e_ctr;
  logic [ADDR_W-1:0]   new_dest, e_dest;

  always_comb begin
    idx  = pc4[IDX_BITS+1:2];
    ptag = pc4[ADDR_W-1:IDX_BITS+2];
    uidx = upd_pc4[IDX_BITS+1:2];
    utag = upd_pc4[ADDR_W-1:IDX_BITS+2];
    uhit = valid_q[uidx] && tag_q[uidx] == utag;
    u_ctr = ctr_q[uidx];
    new_ctr = !uhit ? CTR_WT :
              upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + 1'b1) :
              (u_ctr == '0 ? u_ctr : u_ctr - 1'b1);
    new_dest = upd_taken ? upd_dest : dest_q[uidx];
    // a not-taken miss writes nothing, so it must not forward either
    wr  = upd_valid && !rst && !flush && (uhit || upd_taken);
    fwd = wr && idx == uidx;
    e_valid = fwd || valid_q[idx];
    e_tag   = fwd ? utag : tag_q[idx];
    e_ctr   = fwd ? new_ctr : ctr_q[idx];
    e_dest  = fwd ? new_dest : dest_q[idx];
    hit        = !flush && e_valid && e_tag == ptag;
    pred_taken = hit && e_ctr[CTR_BITS-1];
    pred_dest  = hit ? e_dest : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        dest_q[i] <= '0;
        ctr_q[i]  <= CTR_WN;
      end
      valid_q       <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches == STAT_MAX ? stat_branches : stat_branches + 1'b1;
      if (upd_mispred && stat_mispred != STAT_MAX) stat_mispred <= stat_mispred + 1'b1;
      if (wr) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        dest_q[uidx]  <= new_dest;
        ctr_q[uidx]   <= new_ctr;
      end
    end
  end
endmodule
